// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 trap controller: FSM states, interrupt codes,
// exception code width and mie/mip bit positions.
package jedro_1_defines;

  typedef logic [1:0] trap_state_t;

  localparam trap_state_t ST_IDLE = 2'd0;
  localparam trap_state_t ST_SAVE = 2'd1;
  localparam trap_state_t ST_JUMP = 2'd2;

  localparam int unsigned EXC_CODE_W = 4;

  localparam logic [EXC_CODE_W-1:0] IRQ_CODE_MEI = 4'd11;
  localparam logic [EXC_CODE_W-1:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [EXC_CODE_W-1:0] IRQ_CODE_MTI = 4'd7;

  // Bit positions inside mie/mip as {meip, mtip, msip}
  localparam int unsigned IRQ_IDX_MSI = 0;
  localparam int unsigned IRQ_IDX_MTI = 1;
  localparam int unsigned IRQ_IDX_MEI = 2;

endpackage

// File: rtl/jedro_1_irq_arbiter.sv
// Fixed-priority interrupt selector: MEI > MSI > MTI.
module jedro_1_irq_arbiter
  import jedro_1_defines::*;
(
  input  logic [2:0]            pending_i,
  output logic                  valid_o,
  output logic [EXC_CODE_W-1:0] code_o
);

  always_comb begin
    valid_o = |pending_i;
    code_o  = '0;
    if (pending_i[IRQ_IDX_MEI]) begin
      code_o = IRQ_CODE_MEI;
    end else if (pending_i[IRQ_IDX_MSI]) begin
      code_o = IRQ_CODE_MSI;
    end else if (pending_i[IRQ_IDX_MTI]) begin
      code_o = IRQ_CODE_MTI;
    end
  end

endmodule

// File: rtl/jedro_1_trap_ctrl.sv
// Trap controller: arbitrates exceptions, MRET and interrupts, updates CSRs, redirects fetch.
// Optional JEDRO_1_VECTORED_IRQ_EN: interrupts jump to base + 4*code.
module jedro_1_trap_ctrl
  import jedro_1_defines::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mstatus_mie_i,
  input  logic [2:0]            mie_i,
  input  logic [2:0]            mip_i,
  input  logic [DATA_WIDTH-3:0] mtvec_base_i,
  input  logic [DATA_WIDTH-1:0] mepc_i,
  input  logic                  instr_boundary_i,
  input  logic [DATA_WIDTH-1:0] next_pc_i,
  input  logic                  exc_valid_i,
  input  logic [EXC_CODE_W-1:0] exc_cause_i,
  input  logic [DATA_WIDTH-1:0] exc_pc_i,
  input  logic [DATA_WIDTH-1:0] exc_tval_i,
  input  logic                  mret_i,
  input  logic                  trap_ack_i,
  output logic                  trap_req_o,
  output logic [DATA_WIDTH-1:0] trap_pc_o,
  output logic                  flush_o,
  output logic                  csr_trap_we_o,
  output logic                  csr_mret_we_o,
  output logic [DATA_WIDTH-1:0] csr_mepc_o,
  output logic [DATA_WIDTH-1:0] csr_mcause_o,
  output logic [DATA_WIDTH-1:0] csr_mtval_o
);

  trap_state_t           r_state;
  trap_state_t           w_state_next;
  logic [DATA_WIDTH-1:0] r_mepc,    w_mepc_next;
  logic [DATA_WIDTH-1:0] r_mcause,  w_mcause_next;
  logic [DATA_WIDTH-1:0] r_mtval,   w_mtval_next;
  logic [DATA_WIDTH-1:0] r_trap_pc, w_trap_pc_next;
  logic                  w_take;
  logic                  w_mret_take;
  logic [2:0]            w_pending;
  logic                  w_irq_valid;
  logic [EXC_CODE_W-1:0] w_irq_code;
  logic [DATA_WIDTH-1:0] w_base;
  logic [DATA_WIDTH-1:0] w_irq_target;

  assign w_pending = mip_i & mie_i;
  assign w_base    = {mtvec_base_i, 2'b00};

  jedro_1_irq_arbiter u_irq_arbiter (
    .pending_i (w_pending),
    .valid_o   (w_irq_valid),
    .code_o    (w_irq_code)
  );

`ifdef JEDRO_1_VECTORED_IRQ_EN
  assign w_irq_target = {mtvec_base_i + (DATA_WIDTH-2)'(w_irq_code), 2'b00};
`else
  assign w_irq_target = w_base;
`endif

  // Next-state and capture logic; arbitration only happens in IDLE out of reset
  always_comb begin
    w_state_next   = r_state;
    w_mepc_next    = r_mepc;
    w_mcause_next  = r_mcause;
    w_mtval_next   = r_mtval;
    w_trap_pc_next = r_trap_pc;
    w_take         = 1'b0;
    w_mret_take    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rst_i) begin
          if (exc_valid_i) begin
            w_take         = 1'b1;
            w_state_next   = ST_SAVE;
            w_mepc_next    = exc_pc_i;
            w_mcause_next  = DATA_WIDTH'(exc_cause_i);
            w_mtval_next   = exc_tval_i;
            w_trap_pc_next = w_base;
          end else if (mret_i) begin
            w_take         = 1'b1;
            w_mret_take    = 1'b1;
            w_state_next   = ST_JUMP;
            w_trap_pc_next = mepc_i;
          end else if (mstatus_mie_i && w_irq_valid && instr_boundary_i) begin
            w_take         = 1'b1;
            w_state_next   = ST_SAVE;
            w_mepc_next    = next_pc_i;
            w_mcause_next  = {1'b1, (DATA_WIDTH-1)'(w_irq_code)};
            w_mtval_next   = '0;
            w_trap_pc_next = w_irq_target;
          end
        end
      end
      ST_SAVE: w_state_next = ST_JUMP;
      ST_JUMP: begin
        if (trap_ack_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_mepc    <= '0;
      r_mcause  <= '0;
      r_mtval   <= '0;
      r_trap_pc <= '0;
    end else begin
      r_state   <= w_state_next;
      r_mepc    <= w_mepc_next;
      r_mcause  <= w_mcause_next;
      r_mtval   <= w_mtval_next;
      r_trap_pc <= w_trap_pc_next;
    end
  end

  // flush and mret pulse must already be visible on the cycle the event is accepted
  assign flush_o       = (r_state != ST_IDLE) || w_take;
  assign csr_mret_we_o = w_mret_take;
  assign csr_trap_we_o = (r_state == ST_SAVE);
  assign trap_req_o    = (r_state == ST_JUMP);
  assign trap_pc_o     = r_trap_pc;
  assign csr_mepc_o    = r_mepc;
  assign csr_mcause_o  = r_mcause;
  assign csr_mtval_o   = r_mtval;

endmodule

// File: tb/tb_jedro_1_trap_ctrl.sv
// Self-checking bench for jedro_1_trap_ctrl: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_jedro_1_trap_ctrl;

  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          mstatus_mie_i;
  logic [2:0]    mie_i, mip_i;
  logic [DW-3:0] mtvec_base_i;
  logic [DW-1:0] mepc_i, next_pc_i, exc_pc_i, exc_tval_i;
  logic          instr_boundary_i, exc_valid_i, mret_i, trap_ack_i;
  logic [3:0]    exc_cause_i;
  logic          trap_req_o, flush_o, csr_trap_we_o, csr_mret_we_o;
  logic [DW-1:0] trap_pc_o, csr_mepc_o, csr_mcause_o, csr_mtval_o;

  int n_checks = 0;
  int n_errors = 0;

  jedro_1_trap_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i),
    .mip_i(mip_i), .mtvec_base_i(mtvec_base_i), .mepc_i(mepc_i),
    .instr_boundary_i(instr_boundary_i), .next_pc_i(next_pc_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
    .exc_tval_i(exc_tval_i), .mret_i(mret_i), .trap_ack_i(trap_ack_i),
    .trap_req_o(trap_req_o), .trap_pc_o(trap_pc_o), .flush_o(flush_o),
    .csr_trap_we_o(csr_trap_we_o), .csr_mret_we_o(csr_mret_we_o),
    .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o), .csr_mtval_o(csr_mtval_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet();
    exc_valid_i = 1'b0; mret_i = 1'b0; mip_i = 3'b000; trap_ack_i = 1'b0;
  endtask

  task automatic randomize_inputs();
    exc_valid_i      = ($urandom_range(0, 3) == 0);
    mret_i           = ($urandom_range(0, 3) == 0);
    mstatus_mie_i    = 1'($urandom);
    mie_i            = 3'($urandom);
    mip_i            = 3'($urandom);
    instr_boundary_i = 1'($urandom);
    mtvec_base_i     = (DW-2)'($urandom);
    mepc_i           = $urandom;
    next_pc_i        = $urandom;
    exc_pc_i         = $urandom;
    exc_tval_i       = $urandom;
    exc_cause_i      = 4'($urandom);
    trap_ack_i       = 1'($urandom);
  endtask

  // Reference: interrupt code by fixed priority MEI(11) > MSI(3) > MTI(7)
  function automatic int irq_code(input logic [2:0] mip, input logic [2:0] mie);
    logic [2:0] p;
    p = mip & mie;
    if (p[2]) return 11;
    if (p[0]) return 3;
    if (p[1]) return 7;
    return 0;
  endfunction

  // One full transaction from the current inputs; scramble drives noise while busy
  task automatic do_txn(input int ack_dly, input bit scramble);
    bit is_exc, is_mret, is_irq, taken;
    logic [DW-1:0] e_mepc, e_mcause, e_mtval, e_target;
    #2;
    is_exc  = exc_valid_i;
    is_mret = !is_exc && mret_i;
    is_irq  = !is_exc && !is_mret && mstatus_mie_i && ((mip_i & mie_i) != 0) && instr_boundary_i;
    taken   = is_exc || is_mret || is_irq;
    e_mepc = 0; e_mcause = 0; e_mtval = 0; e_target = 0;
    if (is_exc) begin
      e_mepc = exc_pc_i; e_mcause = DW'(exc_cause_i); e_mtval = exc_tval_i;
      e_target = DW'(mtvec_base_i) * 4;
    end else if (is_mret) begin
      e_target = mepc_i;
    end else if (is_irq) begin
      e_mepc = next_pc_i;
      e_mcause = 32'h8000_0000 + DW'(irq_code(mip_i, mie_i));
`ifdef JEDRO_1_VECTORED_IRQ_EN
      e_target = DW'(mtvec_base_i) * 4 + 4 * DW'(irq_code(mip_i, mie_i));
`else
      e_target = DW'(mtvec_base_i) * 4;
`endif
    end
    check("accept_flush", DW'(flush_o), DW'(taken));
    check("accept_mret_we", DW'(csr_mret_we_o), DW'(is_mret));
    check("accept_trap_we", DW'(csr_trap_we_o), 0);
    check("accept_trap_req", DW'(trap_req_o), 0);
    step();
    if (!taken) return;
    if (!is_mret) begin
      if (scramble) randomize_inputs(); else quiet();
      #2;
      check("save_trap_we", DW'(csr_trap_we_o), 1);
      check("save_mepc", csr_mepc_o, e_mepc);
      check("save_mcause", csr_mcause_o, e_mcause);
      check("save_mtval", csr_mtval_o, e_mtval);
      check("save_flush", DW'(flush_o), 1);
      check("save_trap_req", DW'(trap_req_o), 0);
      check("save_mret_we", DW'(csr_mret_we_o), 0);
      step();
    end
    for (int k = 0; k <= ack_dly; k++) begin
      if (scramble) randomize_inputs(); else quiet();
      trap_ack_i = (k == ack_dly);
      #2;
      check("jump_req", DW'(trap_req_o), 1);
      check("jump_pc", trap_pc_o, e_target);
      check("jump_flush", DW'(flush_o), 1);
      check("jump_trap_we", DW'(csr_trap_we_o), 0);
      check("jump_mret_we", DW'(csr_mret_we_o), 0);
      step();
    end
    quiet();
    #2;
    check("after_req", DW'(trap_req_o), 0);
    check("after_flush", DW'(flush_o), 0);
  endtask

  initial begin
    rst_i = 1'b1;
    quiet();
    mstatus_mie_i = 0; mie_i = 0; instr_boundary_i = 0; mtvec_base_i = 0;
    mepc_i = 0; next_pc_i = 0; exc_pc_i = 0; exc_tval_i = 0; exc_cause_i = 0;
    step(); step();
    #2;
    check("rst_req", DW'(trap_req_o), 0);
    check("rst_flush", DW'(flush_o), 0);
    check("rst_trap_we", DW'(csr_trap_we_o), 0);
    check("rst_mret_we", DW'(csr_mret_we_o), 0);
    check("rst_pc", trap_pc_o, 0);
    check("rst_mepc", csr_mepc_o, 0);
    check("rst_mcause", csr_mcause_o, 0);
    check("rst_mtval", csr_mtval_o, 0);
    rst_i = 1'b0;
    step();

    // Exception with cause 2 at 0x100
    exc_valid_i = 1; exc_cause_i = 4'd2; exc_pc_i = 32'h100; exc_tval_i = 32'hDEAD;
    mtvec_base_i = 30'h20;
    do_txn(2, 0);

    // All interrupts pending: MEI wins
    mstatus_mie_i = 1; mie_i = 3'b111; mip_i = 3'b111; instr_boundary_i = 1;
    next_pc_i = 32'h44;
    do_txn(0, 0);

    // Exception and MRET together: exception wins
    exc_valid_i = 1; mret_i = 1; exc_cause_i = 4'd5;
    do_txn(1, 0);

    // MRET with ack held off five cycles
    mret_i = 1; mepc_i = 32'h200;
    do_txn(5, 0);

    // Interrupt pending but globally disabled, then without instruction boundary
    mstatus_mie_i = 0; mie_i = 3'b111; mip_i = 3'b111; instr_boundary_i = 1;
    do_txn(0, 0);
    #2; check("mie0_no_save", DW'(csr_trap_we_o), 0);
    mstatus_mie_i = 1; instr_boundary_i = 0; mip_i = 3'b010; mie_i = 3'b010;
    do_txn(0, 0);
    #2; check("nobnd_no_save", DW'(csr_trap_we_o), 0);
    quiet(); step();

    // Reset during JUMP drops the redirect
    exc_valid_i = 1; exc_cause_i = 4'd7; exc_pc_i = 32'h300; exc_tval_i = 32'h1;
    step(); quiet(); step();
    #2; check("pre_rst_jump", DW'(trap_req_o), 1);
    rst_i = 1; step(); rst_i = 0;
    #2;
    check("rstj_req", DW'(trap_req_o), 0);
    check("rstj_flush", DW'(flush_o), 0);
    check("rstj_pc", trap_pc_o, 0);
    check("rstj_mepc", csr_mepc_o, 0);
    check("rstj_mcause", csr_mcause_o, 0);
    step();

    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      trap_ack_i = 0;
      do_txn(int'($urandom_range(0, 4)), 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jedro_1_trap_ctrl.md
JEDRO_1_TRAP_CTRL -- requirements
Module: jedro_1_trap_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the datapath and PC width.
REQ-002 SHALL have ports, clock and reset first; one clock, reset synchronous and active-high:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mstatus_mie_i  in  1  global interrupt enable, from CSR
- mie_i  in  3  {meie,mtie,msie}, from CSR
- mip_i  in  3  {meip,mtip,msip}, from CSR
- mtvec_base_i  in  DATA_WIDTH-2  trap vector base, word address
- mepc_i  in  DATA_WIDTH  current mepc, return target
- instr_boundary_i  in  1  pipeline at an instruction boundary; interrupt may be taken
- next_pc_i  in  DATA_WIDTH  PC of the next unexecuted instruction
- exc_valid_i  in  1  synchronous exception from the decoder
- exc_cause_i  in  4  exception code
- exc_pc_i  in  DATA_WIDTH  faulting instruction PC
- exc_tval_i  in  DATA_WIDTH  trap value
- mret_i  in  1  decoded MRET
- trap_ack_i  in  1  fetch accepted the redirect
- trap_req_o  out  1  redirect request to fetch
- trap_pc_o  out  DATA_WIDTH  redirect target
- flush_o  out  1  kill younger pipeline contents
- csr_trap_we_o  out  1  one-cycle pulse: CSR writes mepc/mcause/mtval, mpie<=mie, mie<=0
- csr_mret_we_o  out  1  one-cycle pulse: CSR sets mie<=mpie, mpie<=1
- csr_mepc_o  out  DATA_WIDTH  value for mepc
- csr_mcause_o  out  DATA_WIDTH  value for mcause
- csr_mtval_o  out  DATA_WIDTH  value for mtval

Function
REQ-003 SHALL implement an FSM with states IDLE, SAVE and JUMP.
REQ-004 Pending interrupt SHALL be defined as mstatus_mie_i & |(mip_i & mie_i).
REQ-005 In IDLE the FSM SHALL arbitrate with priority exc_valid_i > mret_i > (pending interrupt & instr_boundary_i).
REQ-006 On an exception, IDLE->SAVE; SHALL latch mepc=exc_pc_i, mcause={0,exc_cause_i} zero-extended, mtval=exc_tval_i.
REQ-007 On an interrupt, IDLE->SAVE; SHALL latch mepc=next_pc_i, mcause bit DATA_WIDTH-1=1 with code MEI=11 > MSI=3 > MTI=7 (fixed priority), mtval=0.
REQ-008 On MRET, SHALL pulse csr_mret_we_o for 1 cycle, latch trap_pc_o=mepc_i, and go IDLE->JUMP (SAVE skipped).
REQ-009 SAVE SHALL last exactly 1 cycle with csr_trap_we_o=1, then go to JUMP; csr_mepc_o/csr_mcause_o/csr_mtval_o SHALL be valid while csr_trap_we_o=1.
REQ-010 Trap target SHALL be {mtvec_base_i,2'b00}, sampled on the IDLE exit cycle.
REQ-011 In JUMP, trap_req_o=1 and trap_pc_o SHALL stay stable until trap_ack_i=1; the FSM SHALL then return to IDLE (ack in the same cycle allowed).
REQ-012 flush_o SHALL be 1 in every non-IDLE state and on the IDLE exit cycle.
REQ-013 All event inputs SHALL be ignored outside IDLE; a deasserted interrupt is not remembered.
REQ-014 Latency SHALL be: event accepted at cycle N -> csr_trap_we_o at N+1 -> trap_req_o from N+2; for MRET, trap_req_o from N+1.
REQ-015 A pending interrupt with instr_boundary_i=0 SHALL NOT cause a transition.

Reset
REQ-016 With rst_i=1 at a clock edge, the FSM SHALL go to IDLE and every output and latched register SHALL be 0, including mid-SAVE or mid-JUMP; a pending redirect is dropped.

Configuration
REQ-017 With JEDRO_1_VECTORED_IRQ_EN defined, an interrupt target SHALL be {mtvec_base_i,2'b00} + 4*code and exceptions SHALL still use the base.
REQ-018 Without JEDRO_1_VECTORED_IRQ_EN, all traps SHALL use the direct base.

Structure
REQ-019 jedro_1_defines SHALL hold: the FSM state typedef, interrupt codes (11/3/7), the exception code width (4), and mie/mip bit indices.
REQ-020 Interrupt prioritisation SHALL be a combinational sub-module jedro_1_irq_arbiter (inputs pending vector, outputs valid + 4-bit code).

Verification
REQ-021 exc_valid_i=1, cause=2, exc_pc_i=0x100, tval=0xDEAD, mtvec_base_i=0x20 -> csr_trap_we_o at N+1 with mepc=0x100, mcause=2, mtval=0xDEAD; trap_pc_o=0x80 until ack.
REQ-022 mip_i=mie_i=3'b111, mie=1, boundary=1, next_pc_i=0x44 -> mcause=0x8000000B, mepc=0x44; with vectored EN, trap_pc_o=0x80+44=0xAC.
REQ-023 exc_valid_i and mret_i in the same cycle -> exception taken, csr_mret_we_o stays 0.
REQ-024 mret_i=1, mepc_i=0x200 -> csr_mret_we_o 1-cycle pulse, trap_req_o next cycle with trap_pc_o=0x200; trap_ack_i held low 5 cycles -> target stable, then IDLE.
REQ-025 rst_i asserted during JUMP -> next cycle trap_req_o=0, flush_o=0, FSM in IDLE.
REQ-026 Pending interrupt with mstatus_mie_i=0, or with instr_boundary_i=0 -> no flush_o and no csr_trap_we_o.
